// File: rtl/dispense_sequencer_pkg.sv
// Shared definitions for the dispense sequencer: FSM state codes, the
// 28BYJ48 half-step coil table and the channel-select width helper.
package dispense_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_DWELL = 3'd2,
    ST_REV   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } state_t;

  // Half-step sequence, coil A in bit 3 down to coil D in bit 0.
  function automatic logic [3:0] phase_coils(input logic [2:0] idx);
    logic [3:0] c;
    case (idx)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
    return c;
  endfunction

  // Width of the channel select: max(1, clog2(n)).
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dispense_sequencer_debouncer.sv
// switch_debouncer: 2-FF synchronizer followed by a stable-count filter.
// Ports:
//   clk_50MHz  system clock
//   rst        asynchronous reset, active-low
//   raw        asynchronous switch input
//   deb        debounced level; follows raw only after DEB_CYCLES equal samples
module switch_debouncer #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
      deb <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // cnt counts consecutive samples that disagree with the current output
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// dispense_sequencer: runs one selected hopper channel through `maximo`
// forward / dwell / reverse strokes of a 28BYJ48 stepper between two limits.
// Ports:
//   clk_50MHz  system clock             rst        async reset, active-low
//   start      level, rising edge runs  abort      level, forces IDLE
//   ch_sel     channel for the run      maximo     stroke count target
//   limit_fwd  raw fwd limits/channel   limit_rev  raw home limits/channel
//   coils      4 coils per channel      dir        0 fwd, 1 rev
//   busy       run in progress          done       1-cycle completion pulse
//   fault      sticky fault flag        rep_count  completed strokes
//   state      FSM state code
module dispense_sequencer
  import dispense_sequencer_pkg::*;
#(
  parameter  int unsigned N_CH        = 2,
  parameter  int unsigned CNT_W       = 4,
  parameter  int unsigned STEP_DIV    = 500000,
  parameter  int unsigned DWELL_TICKS = 200,
  parameter  int unsigned DEB_CYCLES  = 500000,
  parameter  int unsigned MAX_STEPS   = 4096,
  localparam int unsigned CH_W        = ch_w(N_CH)
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  maximo,
  input  logic [N_CH-1:0]   limit_fwd,
  input  logic [N_CH-1:0]   limit_rev,
  output logic [4*N_CH-1:0] coils,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [CNT_W-1:0]  rep_count,
  output logic [2:0]        state
);
  localparam int unsigned DIV_W = $clog2(STEP_DIV + 1);
  localparam int unsigned DW_W  = $clog2(DWELL_TICKS + 1);
  localparam int unsigned SC_W  = $clog2(MAX_STEPS + 1);

  state_t             state_q, state_d;
  logic               start_s1, start_s, start_d, abort_s1, abort_s, start_edge;
  logic [N_CH-1:0]    lf_deb, lr_deb;
  logic               lf, lr;
  logic [DIV_W-1:0]   div_cnt;
  logic               step_tick;
  logic [DW_W-1:0]    dwell_cnt;
  logic [SC_W-1:0]    step_cnt;
  logic [CH_W-1:0]    ch_q;
  logic [CNT_W-1:0]   target_q;
  logic [2:0]         phase_q [N_CH];
  logic               accept, clr_cnt, step_fwd, step_rev, dwell_inc, rep_inc, set_fault;

  for (genvar k = 0; k < N_CH; k++) begin : g_deb
    switch_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_fwd (
      .clk_50MHz(clk_50MHz), .rst(rst), .raw(limit_fwd[k]), .deb(lf_deb[k]));
    switch_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_rev (
      .clk_50MHz(clk_50MHz), .rst(rst), .raw(limit_rev[k]), .deb(lr_deb[k]));
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      start_s1 <= '0;
      start_s  <= '0;
      start_d  <= '0;
      abort_s1 <= '0;
      abort_s  <= '0;
      div_cnt  <= '0;
    end else begin
      start_s1 <= start;
      start_s  <= start_s1;
      start_d  <= start_s;
      abort_s1 <= abort;
      abort_s  <= abort_s1;
      div_cnt  <= step_tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign start_edge = start_s & ~start_d;
  assign step_tick  = (div_cnt == DIV_W'(STEP_DIV - 1));

  always_comb begin
    lf = 1'b0;
    lr = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (CH_W'(k) == ch_q) begin
        lf = lf_deb[k];
        lr = lr_deb[k];
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    clr_cnt   = 1'b0;
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    dwell_inc = 1'b0;
    rep_inc   = 1'b0;
    set_fault = 1'b0;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAULT: begin
          if (start_edge) begin
            accept = 1'b1;
            if (maximo == '0) begin
              state_d = ST_DONE;
            end else if ({1'b0, ch_sel} >= (CH_W + 1)'(N_CH)) begin
              state_d   = ST_FAULT;
              set_fault = 1'b1;
            end else begin
              state_d = ST_FWD;
              clr_cnt = 1'b1;
            end
          end
        end
        ST_FWD: begin
          if (lf && lr) begin
            state_d   = ST_FAULT;
            set_fault = 1'b1;
          end else if (lf) begin
            state_d = ST_DWELL;
            clr_cnt = 1'b1;
          end else if (step_cnt == SC_W'(MAX_STEPS)) begin
            state_d   = ST_FAULT;
            set_fault = 1'b1;
          end else if (step_tick) begin
            step_fwd = 1'b1;
          end
        end
        ST_DWELL: begin
          if (step_tick) begin
            if (dwell_cnt == DW_W'(DWELL_TICKS - 1)) begin
              state_d = ST_REV;
              clr_cnt = 1'b1;
            end else begin
              dwell_inc = 1'b1;
            end
          end
        end
        ST_REV: begin
          if (lf && lr) begin
            state_d   = ST_FAULT;
            set_fault = 1'b1;
          end else if (lr) begin
            state_d = ST_CHECK;
            rep_inc = 1'b1;
          end else if (step_cnt == SC_W'(MAX_STEPS)) begin
            state_d   = ST_FAULT;
            set_fault = 1'b1;
          end else if (step_tick) begin
            step_rev = 1'b1;
          end
        end
        ST_CHECK: begin
          if (rep_count == target_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FWD;
            clr_cnt = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      ch_q      <= '0;
      target_q  <= '0;
      rep_count <= '0;
      fault     <= '0;
      step_cnt  <= '0;
      dwell_cnt <= '0;
      for (int unsigned k = 0; k < N_CH; k++) phase_q[k] <= '0;
    end else begin
      if (accept) begin
        ch_q      <= ch_sel;
        target_q  <= maximo;
        rep_count <= '0;
      end
      if (set_fault)   fault <= 1'b1;
      else if (accept) fault <= 1'b0;
      if (clr_cnt) begin
        step_cnt  <= '0;
        dwell_cnt <= '0;
      end else begin
        if (step_fwd || step_rev) step_cnt  <= step_cnt + 1'b1;
        if (dwell_inc)            dwell_cnt <= dwell_cnt + 1'b1;
      end
      if (rep_inc && rep_count != target_q) rep_count <= rep_count + 1'b1;
      // Phase index is kept per channel so a motor resumes where it stopped.
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (CH_W'(k) == ch_q) begin
          if (step_fwd)      phase_q[k] <= phase_q[k] + 3'd1;
          else if (step_rev) phase_q[k] <= phase_q[k] - 3'd1;
        end
      end
    end
  end

  // Coils are decoded from registered state so an async reset drops them at once.
  always_comb begin
    coils = '0;
    if (state_q == ST_FWD || state_q == ST_REV) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (CH_W'(k) == ch_q) coils[4*k +: 4] = phase_coils(phase_q[k]);
      end
    end
  end

  assign dir   = (state_q == ST_REV);
  assign busy  = (state_q == ST_FWD) || (state_q == ST_DWELL) ||
                 (state_q == ST_REV) || (state_q == ST_CHECK);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule
